// File: rtl/ex_mem_if.sv
// +--------------------------------------------------------------------------+
// | ex_mem_if : EX-side and MEM-side handshake bus of the EX/MEM stage.        |
// | Optional EX_MEM_FWD_EN adds the fwd_* bypass signals.                      |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

interface ex_mem_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     alu_out;
  logic                  alu_zero;
  logic [DATA_W-1:0]     store_data;
  logic [REG_ADDR_W-1:0] dest_reg;
  logic                  ctrl_mem_read;
  logic                  ctrl_mem_write;
  logic                  ctrl_reg_write;
  logic                  ctrl_mem_to_reg;
  logic                  ctrl_branch;
  logic [DATA_W-1:0]     branch_target;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     out_alu_result;
  logic [DATA_W-1:0]     out_store_data;
  logic [REG_ADDR_W-1:0] out_dest_reg;
  logic                  out_mem_read;
  logic                  out_mem_write;
  logic                  out_reg_write;
  logic                  out_mem_to_reg;
  logic                  branch_taken;
  logic [DATA_W-1:0]     branch_pc;
`ifdef EX_MEM_FWD_EN
  logic                  fwd_en;
  logic [REG_ADDR_W-1:0] fwd_rd;
  logic [DATA_W-1:0]     fwd_data;
`endif

  // The stage itself
  modport slave (
`ifdef EX_MEM_FWD_EN
    output fwd_en, fwd_rd, fwd_data,
`endif
    input  in_valid, alu_out, alu_zero, store_data, dest_reg,
    input  ctrl_mem_read, ctrl_mem_write, ctrl_reg_write, ctrl_mem_to_reg,
    input  ctrl_branch, branch_target, flush, out_ready,
    output in_ready, out_valid, out_alu_result, out_store_data, out_dest_reg,
    output out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg,
    output branch_taken, branch_pc
  );

  // The surrounding pipeline (EX producer, MEM consumer, fetch)
  modport master (
`ifdef EX_MEM_FWD_EN
    input  fwd_en, fwd_rd, fwd_data,
`endif
    output in_valid, alu_out, alu_zero, store_data, dest_reg,
    output ctrl_mem_read, ctrl_mem_write, ctrl_reg_write, ctrl_mem_to_reg,
    output ctrl_branch, branch_target, flush, out_ready,
    input  in_ready, out_valid, out_alu_result, out_store_data, out_dest_reg,
    input  out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg,
    input  branch_taken, branch_pc
  );
endinterface

`default_nettype wire

// File: rtl/ex_mem_stage.sv
// +--------------------------------------------------------------------------+
// | ex_mem_stage : EX/MEM register with 2-entry skid buffer and branch        |
// | redirect. Define EX_MEM_FWD_EN to enable the EX operand bypass outputs.   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module ex_mem_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  wire      clk,
  input  wire      rst_n,
  ex_mem_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     store_data;
    logic [REG_ADDR_W-1:0] dest_reg;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic                  mem_to_reg;
  } entry_t;

  state_t            r_state;
  entry_t            r_main;
  entry_t            r_skid;
  logic              r_branch_taken;
  logic [DATA_W-1:0] r_branch_pc;

  entry_t w_in;
  logic   w_accept;
  logic   w_pop;
  logic   w_redirect;

  assign w_in = '{
    alu_result: bus.alu_out,
    store_data: bus.store_data,
    dest_reg:   bus.dest_reg,
    mem_read:   bus.ctrl_mem_read,
    mem_write:  bus.ctrl_mem_write,
    reg_write:  bus.ctrl_reg_write,
    mem_to_reg: bus.ctrl_mem_to_reg
  };

  assign bus.in_ready  = (r_state != TWO);
  assign bus.out_valid = (r_state != EMPTY);
  assign w_accept      = bus.in_valid & bus.in_ready;
  assign w_pop         = bus.out_valid & bus.out_ready;
  assign w_redirect    = w_accept & bus.ctrl_branch & bus.alu_zero & ~bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= EMPTY;
      r_main         <= '0;
      r_skid         <= '0;
      r_branch_taken <= 1'b0;
      r_branch_pc    <= '0;
    end else begin
      // Redirect fires at acceptance, independent of MEM backpressure
      r_branch_taken <= w_redirect;
      if (w_redirect) begin
        r_branch_pc <= bus.branch_target;
      end

      if (bus.flush) begin
        r_state <= EMPTY;
      end else begin
        case (r_state)
          EMPTY: begin
            if (w_accept) begin
              r_main  <= w_in;
              r_state <= ONE;
            end
          end
          ONE: begin
            if (w_accept && !w_pop) begin
              r_skid  <= w_in;
              r_state <= TWO;
            end else if (w_pop && !w_accept) begin
              r_state <= EMPTY;
            end else if (w_accept && w_pop) begin
              r_main  <= w_in;
            end
          end
          TWO: begin
            if (w_pop) begin
              r_main  <= r_skid;
              r_state <= ONE;
            end
          end
          default: r_state <= EMPTY;
        endcase
      end
    end
  end

  assign bus.out_alu_result = r_main.alu_result;
  assign bus.out_store_data = r_main.store_data;
  assign bus.out_dest_reg   = r_main.dest_reg;
  assign bus.out_mem_read   = r_main.mem_read;
  assign bus.out_mem_write  = r_main.mem_write;
  assign bus.out_reg_write  = r_main.reg_write;
  assign bus.out_mem_to_reg = r_main.mem_to_reg;
  assign bus.branch_taken   = r_branch_taken;
  assign bus.branch_pc      = r_branch_pc;

`ifdef EX_MEM_FWD_EN
  // Loads are excluded: their value is not known until after MEM
  assign bus.fwd_en   = bus.out_valid & r_main.reg_write & ~r_main.mem_read &
                        (r_main.dest_reg != '0);
  assign bus.fwd_rd   = r_main.dest_reg;
  assign bus.fwd_data = r_main.alu_result;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
// +--------------------------------------------------------------------------+
// | tb_ex_mem_stage : directed vector bench for ex_mem_stage.                |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ex_mem_stage;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  ex_mem_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

  ex_mem_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] a;
    logic        z;
    logic        br;
    logic [31:0] tgt;
    logic        rdy;
    logic        fl;
    logic        e_ov;
    logic        e_ir;
    logic [31:0] e_res;
    logic        e_bt;
    logic [31:0] e_bpc;
  } vec_t;

  vec_t vecs [24];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic z, input logic br,
                       input logic [31:0] tgt, input logic rw, input logic mr,
                       input logic mw, input logic m2r, input logic [4:0] d,
                       input logic rdy, input logic fl);
    bus.in_valid        = v;
    bus.alu_out         = a;
    bus.alu_zero        = z;
    bus.ctrl_branch     = br;
    bus.branch_target   = tgt;
    bus.ctrl_reg_write  = rw;
    bus.ctrl_mem_read   = mr;
    bus.ctrl_mem_write  = mw;
    bus.ctrl_mem_to_reg = m2r;
    bus.dest_reg        = d;
    bus.store_data      = ~a;
    bus.out_ready       = rdy;
    bus.flush           = fl;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

    //          v     a       z     br    tgt       rdy   fl    ov    ir    res     bt    bpc
    vecs[0]  = '{1'b1, 32'h1,  1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b1, 32'h1,  1'b0, 32'h0};
    vecs[1]  = '{1'b1, 32'h2,  1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b1, 32'h2,  1'b0, 32'h0};
    vecs[2]  = '{1'b1, 32'h3,  1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b1, 32'h3,  1'b0, 32'h0};
    vecs[3]  = '{1'b1, 32'h4,  1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b1, 32'h4,  1'b0, 32'h0};
    vecs[4]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 32'h0};
    vecs[5]  = '{1'b1, 32'hA,  1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 32'hA,  1'b0, 32'h0};
    vecs[6]  = '{1'b1, 32'hB,  1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 32'hA,  1'b0, 32'h0};
    vecs[7]  = '{1'b1, 32'hC,  1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 32'hA,  1'b0, 32'h0};
    vecs[8]  = '{1'b1, 32'hC,  1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b1, 32'hB,  1'b0, 32'h0};
    vecs[9]  = '{1'b1, 32'hC,  1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b1, 32'hC,  1'b0, 32'h0};
    vecs[10] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 32'h0};
    vecs[11] = '{1'b1, 32'h0,  1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0,  1'b1, 32'h100};
    vecs[12] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 32'h100};
    vecs[13] = '{1'b1, 32'h5,  1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 1'b1, 1'b1, 32'h5,  1'b0, 32'h100};
    vecs[14] = '{1'b1, 32'h6,  1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 1'b1, 1'b0, 32'h5,  1'b1, 32'h300};
    vecs[15] = '{1'b1, 32'h7,  1'b1, 1'b1, 32'h400, 1'b0, 1'b0, 1'b1, 1'b0, 32'h5,  1'b0, 32'h300};
    vecs[16] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b1, 32'h6,  1'b0, 32'h300};
    vecs[17] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 32'h300};
    vecs[18] = '{1'b1, 32'h8,  1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 32'h8,  1'b0, 32'h300};
    vecs[19] = '{1'b1, 32'h9,  1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 32'h8,  1'b0, 32'h300};
    vecs[20] = '{1'b1, 32'h10, 1'b1, 1'b1, 32'h500, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,  1'b0, 32'h300};
    vecs[21] = '{1'b1, 32'h12, 1'b1, 1'b1, 32'h600, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,  1'b0, 32'h300};
    vecs[22] = '{1'b1, 32'h11, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b1, 32'h11, 1'b0, 32'h300};
    vecs[23] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 32'h300};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    chk("rst_branch_taken", 32'(bus.branch_taken), 32'h0);
    chk("rst_branch_pc", bus.branch_pc, 32'h0);
    chk("rst_alu_result", bus.out_alu_result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table: control fields are derived from the ALU value so every field is checked
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].a, vecs[i].z, vecs[i].br, vecs[i].tgt,
            vecs[i].a[2], vecs[i].a[0], vecs[i].a[1], vecs[i].a[3],
            vecs[i].a[4:0] ^ 5'h1F, vecs[i].rdy, vecs[i].fl);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_ir));
      chk($sformatf("v%0d_branch_taken", i), 32'(bus.branch_taken), 32'(vecs[i].e_bt));
      chk($sformatf("v%0d_branch_pc", i), bus.branch_pc, vecs[i].e_bpc);
      if (vecs[i].e_ov) begin
        chk($sformatf("v%0d_alu_result", i), bus.out_alu_result, vecs[i].e_res);
        chk($sformatf("v%0d_store_data", i), bus.out_store_data, ~vecs[i].e_res);
        chk($sformatf("v%0d_dest_reg", i), 32'(bus.out_dest_reg), 32'(vecs[i].e_res[4:0] ^ 5'h1F));
        chk($sformatf("v%0d_ctrl", i),
            32'({bus.out_mem_to_reg, bus.out_reg_write, bus.out_mem_write, bus.out_mem_read}),
            32'(vecs[i].e_res[3:0]));
      end
    end

    // Asynchronous reset while both entries are held and a redirect is pending
    @(negedge clk);
    drive(1'b1, 32'h11, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h22, 1'b1, 1'b1, 32'h700, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("pre_rst_in_ready", 32'(bus.in_ready), 32'h0);
    chk("pre_rst_branch_taken", 32'(bus.branch_taken), 32'h1);
    @(negedge clk);
    drive(1'b1, 32'h33, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'h1);
    chk("arst_branch_taken", 32'(bus.branch_taken), 32'h0);
    chk("arst_alu_result", bus.out_alu_result, 32'h0);
    chk("arst_branch_pc", bus.branch_pc, 32'h0);
    @(posedge clk);
    #1;
    chk("arst_no_accept", 32'(bus.out_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'h0);

`ifdef EX_MEM_FWD_EN
    @(negedge clk);
    drive(1'b1, 32'h55, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("fwd_en_alu", 32'(bus.fwd_en), 32'h1);
    chk("fwd_rd", 32'(bus.fwd_rd), 32'h7);
    chk("fwd_data", bus.fwd_data, 32'h55);
    @(negedge clk);
    drive(1'b1, 32'h66, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("fwd_en_load", 32'(bus.fwd_en), 32'h0);
    @(negedge clk);
    drive(1'b1, 32'h77, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("fwd_en_r0", 32'(bus.fwd_en), 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("fwd_en_empty", 32'(bus.fwd_en), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
